tk_dr_sync_rx: RTL and testbench

//  Clocked receiver terminating a Teak dual-rail, return-to-zero (4-phase) push channel.
//  The sender side is built from the tkg_* gate cells.

---
 rtl/tk_dr_sync_rx.sv | 134 +++++++++++++
 tb/tb_tk_dr_sync_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tk_dr_sync_rx.sv
// Teak dual-rail 4-phase push receiver: per-rail synchronisers, completion/spacer
// detection, registered acknowledge and a small circular FIFO on a valid/ready stream.
module tk_dr_sync_rx #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           i_0r0,
  input  logic [WIDTH-1:0]           i_0r1,
  output logic                       i_0a,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  input  logic                       o_ready,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  // Output stream handshake: a word transfers on every rising edge where
  // o_valid and o_ready are both high; o_data is held while o_valid & !o_ready.

  logic [WIDTH-1:0] r0_sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] r0_sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] r1_sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] r1_sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] mem_q     [DEPTH];
  logic [WIDTH-1:0] mem_d     [DEPTH];

  state_t          state_q, state_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;

  logic [WIDTH-1:0] r0s, r1s;
  logic             complete, spacer, illegal, full, push, pop;

  always_comb begin
    r0_sync_d[0] = i_0r0;
    r1_sync_d[0] = i_0r1;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      r0_sync_d[s] = r0_sync_q[s-1];
      r1_sync_d[s] = r1_sync_q[s-1];
    end
  end

  assign r0s      = r0_sync_q[SYNC_STAGES-1];
  assign r1s      = r1_sync_q[SYNC_STAGES-1];
  assign complete = &(r0s ^ r1s);
  assign spacer   = ~|(r0s | r1s);
  assign illegal  = |(r0s & r1s);
  // Full uses the registered level, so a same-cycle pop never frees a slot early.
  assign full     = (level_q == LW'(DEPTH));
  assign pop      = (level_q != '0) && o_ready;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (complete && !full) begin
          push    = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (spacer) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ack_d = (state_d == ST_ACK);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    err_d    = err_q | illegal;
    if (push) begin
      mem_d[wr_ptr_q] = r1s;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r0_sync_q[s] <= '0;
        r1_sync_q[s] <= '0;
      end
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      r0_sync_q <= r0_sync_d;
      r1_sync_q <= r1_sync_d;
      state_q   <= state_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign i_0a    = ack_q;
  assign o_valid = (level_q != '0);
  assign o_data  = mem_q[rd_ptr_q];
  assign o_level = level_q;
  assign err     = err_q | illegal;

endmodule

// File: tb/tb_tk_dr_sync_rx.sv
// Directed bench for tk_dr_sync_rx: dual-rail sender tasks, scoreboard of
// expected words checked on every stream pop, immediate-assertion checks.
module tb_tk_dr_sync_rx;

  logic       clk;
  logic       reset_n;
  logic [7:0] i_0r0, i_0r1;
  logic       i_0a;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_ready;
  logic [2:0] o_level;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  tk_dr_sync_rx #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_0r0   (i_0r0),
    .i_0r1   (i_0r1),
    .i_0a    (i_0a),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ready (o_ready),
    .o_level (o_level),
    .err     (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver tasks
  task automatic drive_word(input logic [7:0] d);
    i_0r1 = d;
    i_0r0 = ~d;
  endtask

  task automatic drive_spacer();
    i_0r1 = '0;
    i_0r0 = '0;
  endtask

  task automatic wait_ack(input logic v, input string tag);
    int n = 0;
    while (i_0a !== v && n < 40) begin
      cyc(1);
      n++;
    end
    check(tag, {31'd0, i_0a}, {31'd0, v});
  endtask

  task automatic send_full(input logic [7:0] d);
    drive_word(d);
    exp_q.push_back(d);
    wait_ack(1'b1, "ack_rise");
    drive_spacer();
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic drain();
    int n = 0;
    o_ready = 1'b1;
    while (o_level !== 3'd0 && n < 40) begin
      cyc(1);
      n++;
    end
    o_ready = 1'b0;
    check("drain_level", {29'd0, o_level}, 32'd0);
    check("drain_sb_empty", exp_q.size(), 32'd0);
  endtask

  // scoreboard: compare head against expected queue whenever a pop will happen
  always begin
    @(negedge clk);
    #1;
    if (reset_n === 1'b1 && o_valid === 1'b1 && o_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {24'd0, o_data}, 32'hFFFF_FFFF);
      end else begin
        check("pop_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] d;
    reset_n = 1'b0;
    o_ready = 1'b0;
    drive_spacer();
    cyc(3);
    check("rst_ack", {31'd0, i_0a}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_level", {29'd0, o_level}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset_n = 1'b1;
    cyc(1);

    // 1: single word, exact ack latency both ways
    drive_word(8'hA5);
    exp_q.push_back(8'hA5);
    cyc(2);
    check("t1_ack_early", {31'd0, i_0a}, 32'd0);
    cyc(1);
    check("t1_ack_rise", {31'd0, i_0a}, 32'd1);
    check("t1_valid", {31'd0, o_valid}, 32'd1);
    check("t1_data", {24'd0, o_data}, 32'hA5);
    check("t1_level", {29'd0, o_level}, 32'd1);
    drive_spacer();
    cyc(2);
    check("t1_ack_hold", {31'd0, i_0a}, 32'd1);
    cyc(1);
    check("t1_ack_fall", {31'd0, i_0a}, 32'd0);
    drain();

    // 2: fill FIFO, fifth word stalls until a slot opens
    for (int w = 1; w <= 4; w++) send_full(8'(w));
    check("t2_level_full", {29'd0, o_level}, 32'd4);
    drive_word(8'h05);
    exp_q.push_back(8'h05);
    cyc(6);
    check("t2_stall_ack", {31'd0, i_0a}, 32'd0);
    check("t2_stall_level", {29'd0, o_level}, 32'd4);
    o_ready = 1'b1;
    cyc(1);
    check("t2_no_ack_same_pop", {31'd0, i_0a}, 32'd0);
    wait_ack(1'b1, "t2_ack_after_pop");
    drive_spacer();
    wait_ack(1'b0, "t2_ack_fall");
    drain();

    // 3: skewed bit arrival, one bit per clock
    d = 8'h3C;
    drive_spacer();
    exp_q.push_back(d);
    for (int b = 0; b < 8; b++) begin
      if (d[b]) i_0r1[b] = 1'b1;
      else      i_0r0[b] = 1'b1;
      cyc(1);
      check("t3_ack_early", {31'd0, i_0a}, 32'd0);
    end
    cyc(1);
    check("t3_ack_early2", {31'd0, i_0a}, 32'd0);
    cyc(1);
    check("t3_ack_rise", {31'd0, i_0a}, 32'd1);
    drive_spacer();
    wait_ack(1'b0, "t3_ack_fall");
    drain();

    // 4: bit 3 with both rails high
    i_0r1 = 8'h08;
    i_0r0 = 8'hFF;
    cyc(1);
    check("t4_err_early", {31'd0, err}, 32'd0);
    cyc(1);
    check("t4_err_set", {31'd0, err}, 32'd1);
    cyc(5);
    check("t4_no_ack", {31'd0, i_0a}, 32'd0);
    check("t4_no_push", {29'd0, o_level}, 32'd0);
    drive_spacer();
    cyc(4);
    check("t4_err_sticky", {31'd0, err}, 32'd1);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    check("t4_err_cleared", {31'd0, err}, 32'd0);
    cyc(3);
    check("t4_err_stays_clear", {31'd0, err}, 32'd0);

    // 5: push coincides with pop at level 2, pointers wrap
    send_full(8'h10);
    send_full(8'h11);
    check("t5_level2", {29'd0, o_level}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      d = 8'h20 + 8'(i);
      drive_word(d);
      exp_q.push_back(d);
      cyc(2);
      o_ready = 1'b1;
      cyc(1);
      o_ready = 1'b0;
      check("t5_level_const", {29'd0, o_level}, 32'd2);
      check("t5_ack", {31'd0, i_0a}, 32'd1);
      drive_spacer();
      wait_ack(1'b0, "t5_ack_fall");
    end
    drain();

    // 6: reset while in ACK, held codeword re-received
    drive_word(8'h5B);
    exp_q.push_back(8'h5B);
    wait_ack(1'b1, "t6_ack_rise");
    check("t6_level1", {29'd0, o_level}, 32'd1);
    reset_n = 1'b0;
    cyc(1);
    check("t6_rst_ack", {31'd0, i_0a}, 32'd0);
    check("t6_rst_valid", {31'd0, o_valid}, 32'd0);
    check("t6_rst_level", {29'd0, o_level}, 32'd0);
    exp_q.delete();
    reset_n = 1'b1;
    exp_q.push_back(8'h5B);
    wait_ack(1'b1, "t6_reack");
    check("t6_level_again", {29'd0, o_level}, 32'd1);
    drive_spacer();
    wait_ack(1'b0, "t6_ack_fall");
    drain();

    check("final_sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
